// File: rtl/sprite_line_scan_pkg.sv
// Shared definitions for the sprite line scanner: attribute word layout,
// per-line limits and the scanner state encoding.
package sprite_pkg;

    localparam int ATTR_Y_LSB     = 0;
    localparam int ATTR_Y_MSB     = 7;
    localparam int ATTR_X_LSB     = 8;
    localparam int ATTR_X_MSB     = 15;
    localparam int ATTR_H_LSB     = 16;
    localparam int ATTR_H_MSB     = 19;
    localparam int ATTR_VALID_BIT = 20;

    localparam int ROW_W = ATTR_H_MSB - ATTR_H_LSB + 1;

    localparam logic [3:0] MAX_HITS_PER_LINE = 4'd8;
    localparam int         NUM_SPRITES       = 256;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_EVAL   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/sprite_line_scan_if.sv
// Bus between the scanner, the external sprite counter, the attribute RAM
// and the line sprite buffer.
interface sprite_line_scan_if;
    logic        start;
    logic [7:0]  line_y;
    logic [7:0]  sprite_num;
    logic        cnt_done;
    logic [31:0] attr_rdata;
    logic [7:0]  attr_raddr;
    logic        next;
    logic        hit_wr;
    logic [7:0]  hit_id;
    logic [7:0]  hit_x;
    logic [3:0]  hit_row;
    logic        busy;
    logic        scan_done;
    logic        overflow;

    modport slave (
        input  start, line_y, sprite_num, cnt_done, attr_rdata,
        output attr_raddr, next, hit_wr, hit_id, hit_x, hit_row,
               busy, scan_done, overflow
    );

    modport master (
        output start, line_y, sprite_num, cnt_done, attr_rdata,
        input  attr_raddr, next, hit_wr, hit_id, hit_x, hit_row,
               busy, scan_done, overflow
    );
endinterface

// File: rtl/sprite_line_scan_y_match.sv
// Combinational vertical range test of one sprite against the scanline.
// Done in 9 bits so sprites running past line 255 clip instead of wrapping.
module sprite_y_match
    import sprite_pkg::*;
(
    input  logic [7:0]       line_y,
    input  logic [7:0]       y,
    input  logic [ROW_W-1:0] height_m1,
    input  logic             valid,
    output logic             hit,
    output logic [ROW_W-1:0] row
);

    logic [8:0] w_line9;
    logic [8:0] w_y9;
    logic [8:0] w_diff;

    assign w_line9 = {1'b0, line_y};
    assign w_y9    = {1'b0, y};
    assign w_diff  = w_line9 - w_y9;

    assign hit = valid && (w_line9 >= w_y9) && (w_diff <= {5'b0, height_m1});
    assign row = w_diff[ROW_W-1:0];

endmodule

// File: rtl/sprite_line_scan.sv
// Walks all sprite attributes once per scanline and writes up to eight
// matching sprites into the line buffer, flagging overflow beyond that.
module sprite_line_scan
    import sprite_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    sprite_line_scan_if.slave  bus
);

    // state     | meaning
    // ST_IDLE   | waiting for start
    // ST_FETCH  | address on RAM, waiting one cycle for read data
    // ST_EVAL   | test sprite, pulse next, maybe write a hit
    // ST_FINISH | scan_done pulse, then back to idle

    logic [1:0]       r_state;
    logic [7:0]       r_line_y;
    logic [3:0]       r_hit_count;
    logic             r_overflow;
    logic             r_hit_wr;
    logic [7:0]       r_hit_id;
    logic [7:0]       r_hit_x;
    logic [ROW_W-1:0] r_hit_row;

    logic             w_hit;
    logic [ROW_W-1:0] w_row;
    logic             w_unused_attr;

    assign w_unused_attr = &{1'b0, bus.attr_rdata[31:ATTR_VALID_BIT+1]};

    sprite_y_match u_y_match (
        .line_y    (r_line_y),
        .y         (bus.attr_rdata[ATTR_Y_MSB:ATTR_Y_LSB]),
        .height_m1 (bus.attr_rdata[ATTR_H_MSB:ATTR_H_LSB]),
        .valid     (bus.attr_rdata[ATTR_VALID_BIT]),
        .hit       (w_hit),
        .row       (w_row)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_line_y    <= 8'd0;
            r_hit_count <= 4'd0;
            r_overflow  <= 1'b0;
            r_hit_wr    <= 1'b0;
            r_hit_id    <= 8'd0;
            r_hit_x     <= 8'd0;
            r_hit_row   <= '0;
        end else begin
            r_hit_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_line_y    <= bus.line_y;
                        r_hit_count <= 4'd0;
                        r_overflow  <= 1'b0;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_EVAL;
                ST_EVAL: begin
                    if (w_hit) begin
                        if (r_hit_count < MAX_HITS_PER_LINE) begin
                            r_hit_wr    <= 1'b1;
                            r_hit_id    <= bus.sprite_num;
                            r_hit_x     <= bus.attr_rdata[ATTR_X_MSB:ATTR_X_LSB];
                            r_hit_row   <= w_row;
                            r_hit_count <= r_hit_count + 4'd1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    r_state <= bus.cnt_done ? ST_FINISH : ST_FETCH;
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // next is decoded from state so the counter advances on the same edge
    // that leaves EVAL, keeping the RAM address ready for the following FETCH.
    assign bus.attr_raddr = bus.sprite_num;
    assign bus.next       = (r_state == ST_EVAL);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.scan_done  = (r_state == ST_FINISH);
    assign bus.hit_wr     = r_hit_wr;
    assign bus.hit_id     = r_hit_id;
    assign bus.hit_x      = r_hit_x;
    assign bus.hit_row    = r_hit_row;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_sprite_line_scan.sv
// Self-checking bench for sprite_line_scan with a behavioural sprite counter
// and a one-cycle-latency attribute RAM.
module tb_sprite_line_scan;

    logic clk;
    logic rst_n;

    sprite_line_scan_if bus();

    sprite_line_scan dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  cnt;
    logic [31:0] ram [256];

    always @(posedge clk) begin
        if (!rst_n) cnt <= 8'd0;
        else if (bus.next) cnt <= cnt + 8'd1;
    end
    assign bus.sprite_num = cnt;
    assign bus.cnt_done   = (cnt == 8'd255);

    always @(posedge clk) bus.attr_rdata <= ram[bus.attr_raddr];

    int checks = 0;
    int errors = 0;

    int         n_hits;
    int         n_done;
    int         lat;
    logic       ovf_at_done;
    logic [7:0] h_id  [16];
    logic [7:0] h_x   [16];
    logic [3:0] h_row [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_attr(input logic [7:0] y, input logic [7:0] x,
                                            input logic [3:0] hm1, input logic v);
        return {11'd0, v, hm1, x, y};
    endfunction

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    endtask

    // Start a scan and watch it until ten cycles past scan_done (or a budget).
    // Cycle 1 is the first cycle after the edge that accepted start.
    task automatic run_scan(input logic [7:0] line, input int restart_at,
                            input logic [7:0] restart_line);
        int cyc;
        n_hits = 0; n_done = 0; lat = -1; ovf_at_done = 1'b0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.line_y = line;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 700) begin
            if (cyc == restart_at) begin
                bus.start  = 1'b1;
                bus.line_y = restart_line;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.hit_wr) begin
                if (n_hits < 16) begin
                    h_id[n_hits]  = bus.hit_id;
                    h_x[n_hits]   = bus.hit_x;
                    h_row[n_hits] = bus.hit_row;
                end
                n_hits++;
            end
            if (bus.scan_done) begin
                n_done++;
                if (lat < 0) begin
                    lat         = cyc;
                    ovf_at_done = bus.overflow;
                end
            end
            if (lat >= 0 && cyc >= lat + 10) break;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
    endtask

    typedef struct {
        logic [7:0] line;
        int         id;
        logic [7:0] y;
        logic [7:0] x;
        logic [3:0] hm1;
        logic       v;
        int         exp_hits;
        logic [3:0] exp_row;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{8'd10,  3,   8'd5,   8'h21, 4'd7,  1'b1, 1, 4'd5};
        vecs[1]  = '{8'd255, 40,  8'd250, 8'h42, 4'd15, 1'b1, 1, 4'd5};
        vecs[2]  = '{8'd2,   40,  8'd250, 8'h42, 4'd15, 1'b1, 0, 4'd0};
        vecs[3]  = '{8'd103, 100, 8'd100, 8'h63, 4'd3,  1'b1, 1, 4'd3};
        vecs[4]  = '{8'd104, 100, 8'd100, 8'h63, 4'd3,  1'b1, 0, 4'd0};
        vecs[5]  = '{8'd99,  100, 8'd100, 8'h63, 4'd3,  1'b1, 0, 4'd0};
        vecs[6]  = '{8'd7,   255, 8'd7,   8'hF0, 4'd0,  1'b1, 1, 4'd0};
        vecs[7]  = '{8'd50,  0,   8'd50,  8'h11, 4'd0,  1'b0, 0, 4'd0};
        vecs[8]  = '{8'd0,   0,   8'd0,   8'h99, 4'd15, 1'b1, 1, 4'd0};
        vecs[9]  = '{8'd12,  77,  8'd5,   8'h7A, 4'd7,  1'b1, 1, 4'd7};
        vecs[10] = '{8'd13,  77,  8'd5,   8'h7A, 4'd7,  1'b1, 0, 4'd0};

        bus.start  = 1'b0;
        bus.line_y = 8'd0;
        rst_n      = 1'b0;
        clear_ram();
        repeat (3) @(negedge clk);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_hit_wr",    bus.hit_wr,    0);
        chk("rst_scan_done", bus.scan_done, 0);
        chk("rst_overflow",  bus.overflow,  0);
        chk("rst_next",      bus.next,      0);
        chk("rst_hit_id",    bus.hit_id,    0);
        rst_n = 1'b1;
        @(negedge clk);

        // single-sprite vectors
        for (int v = 0; v < 11; v++) begin
            clear_ram();
            ram[vecs[v].id] = mk_attr(vecs[v].y, vecs[v].x, vecs[v].hm1, vecs[v].v);
            run_scan(vecs[v].line, 0, 8'd0);
            chk($sformatf("v%0d_latency", v), lat, 513);
            chk($sformatf("v%0d_done_cnt", v), n_done, 1);
            chk($sformatf("v%0d_hits", v), n_hits, vecs[v].exp_hits);
            if (vecs[v].exp_hits == 1 && n_hits == 1) begin
                chk($sformatf("v%0d_hit_id", v), h_id[0], vecs[v].id);
                chk($sformatf("v%0d_hit_x", v), h_x[0], vecs[v].x);
                chk($sformatf("v%0d_hit_row", v), h_row[0], vecs[v].exp_row);
                chk($sformatf("v%0d_id_hold", v), bus.hit_id, vecs[v].id);
            end
            chk($sformatf("v%0d_cnt_wrap", v), cnt, 0);
            chk($sformatf("v%0d_overflow", v), ovf_at_done, 0);
            chk($sformatf("v%0d_busy_after", v), bus.busy, 0);
        end

        // ten sprites on one line: eight written, overflow flagged
        clear_ram();
        for (int i = 0; i < 10; i++) ram[i] = mk_attr(8'd15, 8'(i * 3), 4'd7, 1'b1);
        run_scan(8'd20, 0, 8'd0);
        chk("ovf_hits", n_hits, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_id%0d", i),  h_id[i],  i);
            chk($sformatf("ovf_x%0d", i),   h_x[i],   i * 3);
            chk($sformatf("ovf_row%0d", i), h_row[i], 5);
        end
        chk("ovf_flag_at_done", ovf_at_done, 1);
        chk("ovf_sticky_idle", bus.overflow, 1);
        clear_ram();
        @(negedge clk);
        bus.start  = 1'b1;
        bus.line_y = 8'd20;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ovf_cleared_by_start", bus.overflow, 0);
        begin
            int guard = 0;
            while (!bus.scan_done && guard < 700) begin
                @(negedge clk);
                guard++;
            end
            chk("ovf_rescan_timeout", (guard < 700) ? 1 : 0, 1);
            chk("ovf_rescan_flag", bus.overflow, 0);
        end
        repeat (3) @(negedge clk);

        // start pulsed again mid-scan must be ignored
        clear_ram();
        ram[3] = mk_attr(8'd5, 8'h33, 4'd7, 1'b1);
        run_scan(8'd10, 50, 8'd200);
        chk("restart_done_cnt", n_done, 1);
        chk("restart_latency", lat, 513);
        chk("restart_hits", n_hits, 1);
        chk("restart_row", h_row[0], 5);

        // reset at cycle 100 of a scan
        clear_ram();
        ram[10] = mk_attr(8'd0, 8'h55, 4'd15, 1'b1);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.line_y = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        chk("pre_rst_hit_id", bus.hit_id, 10);
        chk("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy",      bus.busy,      0);
        chk("mid_rst_next",      bus.next,      0);
        chk("mid_rst_hit_wr",    bus.hit_wr,    0);
        chk("mid_rst_scan_done", bus.scan_done, 0);
        chk("mid_rst_hit_id",    bus.hit_id,    0);
        chk("mid_rst_hit_x",     bus.hit_x,     0);
        chk("mid_rst_hit_row",   bus.hit_row,   0);
        chk("mid_rst_overflow",  bus.overflow,  0);
        chk("mid_rst_cnt",       cnt,           0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int dones = 0;
            int busys = 0;
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if (bus.scan_done) dones++;
                if (bus.busy) busys++;
            end
            chk("post_rst_no_done", dones, 0);
            chk("post_rst_no_busy", busys, 0);
        end
        clear_ram();
        ram[0] = mk_attr(8'd5, 8'h09, 4'd0, 1'b1);
        ram[1] = mk_attr(8'd5, 8'h0A, 4'd0, 1'b1);
        run_scan(8'd5, 0, 8'd0);
        chk("post_rst_latency", lat, 513);
        chk("post_rst_hits", n_hits, 2);
        chk("post_rst_first_id", h_id[0], 0);
        chk("post_rst_second_id", h_id[1], 1);
        chk("post_rst_cnt_wrap", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_line_scan.md
SPRITE_LINE_SCAN -- requirements
Module: sprite_line_scan

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; ports are clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  one-cycle request to scan all sprites for the line on line_y.
REQ-005 line_y  input  8  current scanline; captured when start is accepted.
REQ-006 sprite_num  input  8  current index from the downstream-driving sprite counter.
REQ-007 cnt_done  input  1  counter flag, high when sprite_num == 255.
REQ-008 attr_rdata  input  32  attribute RAM read data, valid one cycle after the address: [7:0] y, [15:8] x, [19:16] height-1, [20] valid, [31:21] ignored.
REQ-009 attr_raddr  output  8  attribute RAM read address; equals sprite_num combinationally.
REQ-010 next  output  1  one-cycle pulse that advances the sprite counter.
REQ-011 hit_wr  output  1  one-cycle write strobe into the line sprite buffer.
REQ-012 hit_id / hit_x / hit_row  output  8/8/4  sprite index, x position and row-within-sprite of the hit.
REQ-013 busy  output  1  high from the accepted start until scan_done.
REQ-014 scan_done  output  1  one-cycle pulse at the end of the scan.
REQ-015 overflow  output  1  sticky; set when more than 8 sprites hit on one line.

Function
REQ-016 The state machine SHALL have four states: IDLE, FETCH, EVAL and FINISH.
REQ-017 IDLE transitions:
- start=1 -> latch line_y, clear hit_count and overflow, go to FETCH.
- start while busy SHALL be ignored.
REQ-018 FETCH SHALL wait one cycle for RAM latency and then go to EVAL.
REQ-019 EVAL SHALL:
- pulse next for exactly one cycle;
- go to FINISH if cnt_done=1, otherwise go to FETCH.
- Result: 2 cycles per sprite, 512 cycles per line, and the counter wraps to 0 on the final next.
REQ-020 Hit test in EVAL: valid=1 AND line_y >= y AND (line_y - y) <= height-1, all computed in 9 bits.
- Sprites extending past line 255 are clipped and do not wrap to line 0.
REQ-021 On a hit with hit_count < 8, the module SHALL pulse hit_wr with:
- hit_id = sprite_num;
- hit_x = attr x;
- hit_row = (line_y - y)[3:0];
- and increment hit_count.
REQ-022 On a hit with hit_count == 8, the module SHALL:
- set overflow;
- suppress hit_wr;
- leave hit_count unchanged.
REQ-023 hit_id, hit_x and hit_row SHALL be registered and hold their last value when hit_wr=0.
REQ-024 FINISH SHALL pulse scan_done for one cycle, deassert busy and return to IDLE.
REQ-025 Hits SHALL be written in ascending sprite_num order.
REQ-026 overflow SHALL hold until the next accepted start.

Reset
REQ-027 When rst_n=0 at a clock edge, the module SHALL:
- go to IDLE;
- clear hit_count, overflow, busy, next, hit_wr, scan_done, hit_id, hit_x and hit_row to 0;
- clear the latched line_y to 0.
REQ-028 Reset mid-scan SHALL abort the scan with no scan_done; the counter shares rst_n, so both restart at sprite 0.

Structure
REQ-029 Shared package sprite_pkg SHALL hold:
- the attribute field bit positions;
- MAX_HITS_PER_LINE = 8;
- NUM_SPRITES = 256;
- the state enumeration.
REQ-030 The 9-bit y-range compare SHALL be a combinational sub-module named sprite_y_match, with outputs hit and row.

Verification
REQ-031 Case: reset, then start with line_y=10; sprite 3 = {y=5, h-1=7, valid}; all others invalid.
- Required: exactly one hit_wr, with hit_id=3 and hit_row=5.
- Required: scan_done 513 cycles after start; counter back at 0.
REQ-032 Case: 10 valid sprites (ids 0..9) covering line 20.
- Required: 8 hit_wr for ids 0..7.
- Required: overflow=1 at scan_done, and overflow cleared by the next start.
REQ-033 Case: sprite y=250, h-1=15.
- line_y=255 -> hit with hit_row=5.
- line_y=2 -> no hit (no wrap).
REQ-034 Case: boundary rows on a sprite with y=100, h-1=3.
- line_y=103 -> hit.
- line_y=104 -> no hit.
- line_y=99 -> no hit.
REQ-035 Case: start pulsed again mid-scan.
- Required: ignored, with a single scan_done.
REQ-036 Case: rst_n=0 at cycle 100 of a scan.
- Required: all outputs 0 next cycle and no scan_done.
- Required: a new start scans from sprite 0.
